// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout and identifier types.
// Arbiters and routers treat flits as opaque; field positions live here for the routing logic.
package noc_pkg;

    localparam int FLIT_W      = 11;
    localparam int TYPE_BIT    = 0;
    localparam int DEST_LSB    = 1;
    localparam int DEST_MSB    = 3;
    localparam int PAYLOAD_LSB = 4;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [2:0]        router_id_t;

    function automatic router_id_t flit_dest(input flit_t f);
        return f[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/noc_port_arbiter_rr_grant.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping mod N.
// Shared by every router output port, so it holds no state of its own.
module rr_grant #(
    parameter int N = 3
) (
    input  logic [N-1:0]                      req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
    input  logic                              enable,
    output logic [N-1:0]                      gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        int  cand;
        logic hit;
        gnt  = '0;
        idx  = '0;
        hit  = 1'b0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (enable && !hit && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
                hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter sharing one NoC output link among N requesters,
// with a small output FIFO presented as valid/ready toward the link driver.
module noc_port_arbiter
    import noc_pkg::*;
#(
    parameter int N     = 3,
    parameter int WIDTH = FLIT_W,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 in_valid,
    input  logic [N*WIDTH-1:0]           in_data,
    output logic [N-1:0]                 in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(N)-1:0]         last_grant,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0]    ptr;
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [N-1:0]     gnt;
    logic [IW-1:0]    gidx;
    logic             full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] wdata;

    function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Fullness is judged on registered count only, so out_ready never reaches in_ready.
    assign full = (count == CW'(DEPTH));

    rr_grant #(.N(N)) u_rr_grant (
        .req    (in_valid),
        .ptr    (ptr),
        .enable (!full && !rst),
        .gnt    (gnt),
        .idx    (gidx)
    );

    assign in_ready   = gnt;
    assign push       = |gnt;
    assign pop        = out_valid && out_ready;
    assign wdata      = in_data[int'(gidx)*WIDTH +: WIDTH];
    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            last_grant <= '0;
        end else if (push) begin
            ptr        <= (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
            last_grant <= gidx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= next_slot(wr_ptr);
            if (pop)  rd_ptr <= next_slot(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage is not reset; an empty FIFO masks the head to zero instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    for (genvar i = 0; i < N; i++) begin : g_contract
        a_hold : assert property (@(posedge clk) disable iff (rst)
            (in_valid[i] && !in_ready[i]) |=>
                (in_valid[i] && $stable(in_data[i*WIDTH +: WIDTH])));
    end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Scoreboard bench for noc_port_arbiter: a reference model predicts grants and occupancy,
// and expected flits are queued at grant time and compared when popped at the output.
module tb_noc_port_arbiter;

    localparam int N     = 3;
    localparam int WIDTH = 11;
    localparam int DEPTH = 2;

    logic                       clk;
    logic                       rst;
    logic [N-1:0]               in_valid;
    logic [N*WIDTH-1:0]         in_data;
    logic [N-1:0]               in_ready;
    logic                       out_valid;
    logic [WIDTH-1:0]           out_data;
    logic                       out_ready;
    logic [$clog2(N)-1:0]       last_grant;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    noc_port_arbiter #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .last_grant (last_grant),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] src [N][$];
    logic [WIDTH-1:0] exp_q [$];
    int               m_ptr;
    int               m_count;
    int               m_last;
    logic [N-1:0]     last_acc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_gnt(input logic [N-1:0] v, input int p, input int cnt);
        if (cnt == DEPTH) return '0;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
        end
        return '0;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            in_valid[i] = (src[i].size() > 0);
            in_data[i*WIDTH +: WIDTH] = (src[i].size() > 0) ? src[i][0] : '0;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_ptr   = 0;
        m_count = 0;
        m_last  = 0;
    endtask

    // Called at a negedge: drive, sample 1ns before posedge, update model, return at next negedge.
    task automatic step();
        logic [N-1:0] eg;
        logic [N-1:0] acc;
        logic [N-1:0] vmask;
        bit           pop;
        int           g;
        drive_inputs();
        #4;
        for (int i = 0; i < N; i++) vmask[i] = (src[i].size() > 0);
        check_eq("fifo_count", 32'(fifo_count), 32'(m_count));
        check_eq("last_grant", 32'(last_grant), 32'(m_last));
        eg = model_gnt(vmask, m_ptr, m_count);
        check_eq("in_ready", 32'(in_ready), 32'(eg));
        check_eq("out_valid", 32'(out_valid), 32'(m_count != 0));
        if (m_count != 0) check_eq("out_data", 32'(out_data), 32'(exp_q[0]));
        else              check_eq("out_data_empty", 32'(out_data), 32'd0);
        pop = (m_count != 0) && out_ready;
        if (pop) void'(exp_q.pop_front());
        g = -1;
        for (int i = 0; i < N; i++) if (eg[i]) g = i;
        if (g >= 0) begin
            exp_q.push_back(src[g][0]);
            m_ptr  = (g + 1) % N;
            m_last = g;
        end
        if (g >= 0 && !pop) m_count++;
        else if (g < 0 && pop) m_count--;
        acc = in_valid & in_ready;
        last_acc = acc;
        for (int i = 0; i < N; i++) if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
        @(negedge clk);
    endtask

    function automatic bit busy();
        bit b = (m_count != 0);
        for (int i = 0; i < N; i++) if (src[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain();
        out_ready = 1'b1;
        for (int c = 0; c < 60 && busy(); c++) step();
        check_eq("drained", 32'(busy()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_inputs();
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        model_clear();
        @(negedge clk);

        // Reset with all requesters valid, then round-robin with an unstalled output
        for (int k = 0; k < 4; k++) begin
            src[0].push_back(11'h011);
            src[1].push_back(11'h022);
            src[2].push_back(11'h044);
        end
        drive_inputs();
        #1;
        check_eq("rst_in_ready_all_valid", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("first_grant", 32'(last_acc), 32'b001);
        repeat (15) step();
        drain();

        // Backpressure: inputs 1 and 2 fill the FIFO, then the output resumes
        do_reset();
        out_ready = 1'b0;
        src[1] = '{11'h101, 11'h102, 11'h103};
        src[2] = '{11'h201, 11'h202};
        repeat (5) step();
        check_eq("full_count", 32'(fifo_count), 32'd2);
        out_ready = 1'b1;
        repeat (8) step();
        drain();

        // Simultaneous push and pop hold occupancy at one
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 11; k++) src[0].push_back(WIDTH'($urandom));
        step();
        out_ready = 1'b1;
        repeat (10) step();
        drain();

        // Full with a pop in the same cycle: no grant until the next cycle
        do_reset();
        out_ready = 1'b0;
        src[2] = '{11'h3A1, 11'h3A2, 11'h3A3};
        repeat (3) step();
        out_ready = 1'b1;
        step();
        check_eq("full_pop_no_grant", 32'(last_acc), 32'd0);
        step();
        check_eq("grant_after_pop", 32'(last_acc), 32'b100);
        drain();

        // Asynchronous reset between edges discards queued flits
        do_reset();
        out_ready = 1'b0;
        src[0] = '{11'h0A5};
        src[1] = '{11'h15A};
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_count", 32'(fifo_count), 32'd0);
        check_eq("midrst_out_data", 32'(out_data), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
        model_clear();
        for (int i = 0; i < N; i++) src[i].delete();
        drive_inputs();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        // Random traffic and random output stalls
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < N; i++)
                if (src[i].size() < 3 && $urandom_range(0, 2) == 0)
                    src[i].push_back(WIDTH'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
